// File: rtl/pythag_pkg.sv
// rtl/pythag_pkg.sv - state encoding, default width and latency constants shared by the pythag units
package pythag_pkg;

  typedef enum logic [1:0] {IDLE, SQUARE, ROOT, FINISH} state_e;

  localparam int W_DEFAULT = 8;
  localparam int LAT_OK    = W_DEFAULT + 2;
  localparam int LAT_ERR   = 2;

endpackage

// File: rtl/pythag_leg_if.sv
// rtl/pythag_leg_if.sv - start/busy/done request and result bundle of the leg solver
interface pythag_leg_if #(parameter int W = pythag_pkg::W_DEFAULT);

  logic         start;
  logic [W-1:0] hyp;
  logic [W-1:0] leg_a;
  logic         busy;
  logic         done;
  logic [W-1:0] leg_b;
  logic         err;

  modport master (output start, hyp, leg_a, input busy, done, leg_b, err);
  modport slave  (input start, hyp, leg_a, output busy, done, leg_b, err);

endinterface

// File: rtl/isqrt_step.sv
// rtl/isqrt_step.sv - one combinational restoring square-root iteration
module isqrt_step #(
  parameter int W = 8
) (
  input  logic [W+1:0] rem_in,
  input  logic [W-1:0] root_in,
  input  logic [1:0]   bits_in,
  output logic [W+1:0] rem_out,
  output logic [W-1:0] root_out
);

  logic [W+1:0] rem_sh;
  logic [W+1:0] trial;

  // The remainder never exceeds 2*root, so its top two bits and the root MSB are zero on entry.
  logic unused_hi;
  assign unused_hi = ^{rem_in[W+1:W], root_in[W-1]};

  always_comb begin
    rem_sh = {rem_in[W-1:0], bits_in};
    trial  = {root_in, 2'b01};
    if (rem_sh >= trial) begin
      rem_out  = rem_sh - trial;
      root_out = {root_in[W-2:0], 1'b1};
    end else begin
      rem_out  = rem_sh;
      root_out = {root_in[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/pythag_leg_solver.sv
// rtl/pythag_leg_solver.sv - computes B = floor(sqrt(C*C - A*A)) over W+2 cycles
module pythag_leg_solver
  import pythag_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  pythag_leg_if.slave bus
);

  localparam int            CW        = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] ITER_LAST = CW'(W - 1);

  state_e         state_q, state_d;
  logic [W-1:0]   hyp_q, hyp_d;
  logic [W-1:0]   leg_a_q, leg_a_d;
  logic [2*W-1:0] radicand_q, radicand_d;
  logic [W+1:0]   rem_q, rem_d;
  logic [W-1:0]   root_q, root_d;
  logic [CW-1:0]  iter_q, iter_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [W-1:0]   leg_b_q, leg_b_d;
  logic           err_q, err_d;

  logic [2*W-1:0] c_ext, a_ext, c_sq, a_sq;
  logic [W+1:0]   step_rem;
  logic [W-1:0]   step_root;

  assign c_ext = {{W{1'b0}}, hyp_q};
  assign a_ext = {{W{1'b0}}, leg_a_q};
  assign c_sq  = c_ext * c_ext;
  assign a_sq  = a_ext * a_ext;

  isqrt_step #(.W(W)) u_step (
    .rem_in   (rem_q),
    .root_in  (root_q),
    .bits_in  (radicand_q[2*W-1 -: 2]),
    .rem_out  (step_rem),
    .root_out (step_root)
  );

  always_comb begin
    state_d    = state_q;
    hyp_d      = hyp_q;
    leg_a_d    = leg_a_q;
    radicand_d = radicand_q;
    rem_d      = rem_q;
    root_d     = root_q;
    iter_d     = iter_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    leg_b_d    = leg_b_q;
    err_d      = err_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          hyp_d   = bus.hyp;
          leg_a_d = bus.leg_a;
          busy_d  = 1'b1;
          state_d = SQUARE;
        end
      end
      SQUARE: begin
        if (leg_a_q > hyp_q) begin
          err_d   = 1'b1;
          leg_b_d = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = FINISH;
        end else begin
          radicand_d = c_sq - a_sq;
          rem_d      = '0;
          root_d     = '0;
          iter_d     = '0;
          state_d    = ROOT;
        end
      end
      ROOT: begin
        radicand_d = {radicand_q[2*W-3:0], 2'b00};
        rem_d      = step_rem;
        root_d     = step_root;
        iter_d     = iter_q + 1'b1;
        // Results and done are loaded on the edge entering FINISH so they appear with busy low.
        if (iter_q == ITER_LAST) begin
          err_d   = 1'b0;
          leg_b_d = step_root;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = FINISH;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      hyp_q      <= '0;
      leg_a_q    <= '0;
      radicand_q <= '0;
      rem_q      <= '0;
      root_q     <= '0;
      iter_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      leg_b_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hyp_q      <= hyp_d;
      leg_a_q    <= leg_a_d;
      radicand_q <= radicand_d;
      rem_q      <= rem_d;
      root_q     <= root_d;
      iter_q     <= iter_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      leg_b_q    <= leg_b_d;
      err_q      <= err_d;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.leg_b = leg_b_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_pythag_leg_solver.sv
// tb/tb_pythag_leg_solver.sv - scoreboard bench for pythag_leg_solver
module tb_pythag_leg_solver;
  import pythag_pkg::*;

  localparam int W = W_DEFAULT;

  typedef struct {
    logic [W-1:0] b;
    logic         err;
    int           s;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_fail;
  exp_t sb[$];
  logic         prev_busy;
  logic [W-1:0] last_b;
  logic         last_err;

  pythag_leg_if #(.W(W)) bus ();

  pythag_leg_solver #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] leg_model(input int c, input int a);
    int rad;
    int r;
    rad = c * c - a * a;
    r = 0;
    while ((r + 1) * (r + 1) <= rad) r++;
    return r[W-1:0];
  endfunction

  // Output monitor: every done pops one expectation.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_busy = 1'b0;
    end else begin
      if (bus.done) begin
        if (sb.size() == 0) begin
          check("spurious_done", {31'd0, bus.done}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("leg_b", {24'd0, bus.leg_b}, {24'd0, e.b});
          check("err", {31'd0, bus.err}, {31'd0, e.err});
          check("latency", cyc - e.s + 1, e.err ? LAT_ERR : LAT_OK);
          check("busy_before_done", {31'd0, prev_busy}, 32'd1);
          check("busy_at_done", {31'd0, bus.busy}, 32'd0);
          last_b   = bus.leg_b;
          last_err = bus.err;
        end
      end else if (sb.size() != 0 && prev_busy && !bus.busy) begin
        check("busy_fell_without_done", {31'd0, bus.busy}, 32'd1);
      end
      prev_busy = bus.busy;
    end
  end

  // Caller is positioned at a negedge with the DUT idle.
  task automatic issue(input logic [W-1:0] c, input logic [W-1:0] a,
                       input logic [W-1:0] eb, input logic ee);
    exp_t e;
    bus.start = 1'b1;
    bus.hyp   = c;
    bus.leg_a = a;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    check("hold_leg_b", {24'd0, bus.leg_b}, {24'd0, last_b});
    check("hold_err", {31'd0, bus.err}, {31'd0, last_err});
    check("busy_after_accept", {31'd0, bus.busy}, 32'd1);
    e.b   = eb;
    e.err = ee;
    e.s   = cyc;
    sb.push_back(e);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      check("timeout_pending", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic op(input logic [W-1:0] c, input logic [W-1:0] a,
                    input logic [W-1:0] eb, input logic ee);
    @(negedge clk);
    issue(c, a, eb, ee);
    wait_done(40);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    last_b    = '0;
    last_err  = 1'b0;
    prev_busy = 1'b0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.hyp   = '0;
    bus.leg_a = '0;

    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_leg_b", {24'd0, bus.leg_b}, 32'd0);
    check("rst_err", {31'd0, bus.err}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_no_done", {31'd0, bus.done}, 32'd0);
    end

    op(8'd5, 8'd3, 8'd4, 1'b0);
    op(8'd13, 8'd5, 8'd12, 1'b0);
    op(8'd17, 8'd8, 8'd15, 1'b0);
    op(8'd255, 8'd0, 8'd255, 1'b0);
    op(8'd10, 8'd10, 8'd0, 1'b0);
    op(8'd10, 8'd3, 8'd9, 1'b0);
    op(8'd255, 8'd254, 8'd22, 1'b0);
    op(8'd3, 8'd5, 8'd0, 1'b1);
    op(8'd5, 8'd4, 8'd3, 1'b0);

    // A start during the operation must be ignored, operands included.
    @(negedge clk);
    issue(8'd13, 8'd5, 8'd12, 1'b0);
    repeat (3) @(negedge clk);
    bus.start = 1'b1;
    bus.hyp   = 8'd5;
    bus.leg_a = 8'd3;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(40);

    for (int i = 0; i < 16; i++) begin
      logic [W-1:0] c;
      logic [W-1:0] a;
      c = W'($urandom_range(0, 255));
      a = (i % 4 == 3) ? W'($urandom_range(0, 255)) : W'($urandom_range(0, int'(c)));
      if (a > c) op(c, a, 8'd0, 1'b1);
      else       op(c, a, leg_model(int'(c), int'(a)), 1'b0);
    end

    // Reset in the middle of ROOT aborts the operation without a done pulse.
    @(negedge clk);
    issue(8'd13, 8'd5, 8'd12, 1'b0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    sb.delete();
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_done", {31'd0, bus.done}, 32'd0);
    check("abort_leg_b", {24'd0, bus.leg_b}, 32'd0);
    check("abort_err", {31'd0, bus.err}, 32'd0);
    last_b   = '0;
    last_err = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("abort_no_done", {31'd0, bus.done}, 32'd0);
    end
    op(8'd5, 8'd3, 8'd4, 1'b0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
